// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns LSU LCD writes into timed HD44780 8-bit bus cycles with one pending slot.
// Define LCD_CTRL_INIT_EN to run the HD44780 power-up init sequence after reset.
module lcd_ctrl #(
  parameter int T_SETUP_CYC = 2,
  parameter int T_PULSE_CYC = 23,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_CMD_CYC   = 2000,
  parameter int T_CLR_CYC   = 82000,
  parameter int CNT_W       = 17
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_lcd_word,
  input  logic        i_lcd_wr,
  output logic        o_busy,
  output logic        o_ovf,
  output logic [31:0] o_status,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data
);
`ifdef LCD_CTRL_INIT_EN
  localparam int CW = (CNT_W > 20) ? CNT_W : 20;
  localparam logic [CW-1:0] C_PWR = CW'(750000 - 1);
`else
  localparam int CW = CNT_W;
  localparam logic [CW-1:0] C_PWR = '0;
`endif
  localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP_CYC - 1);
  localparam logic [CW-1:0] C_PULSE = CW'(T_PULSE_CYC - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD_CYC - 1);
  localparam logic [CW-1:0] C_CMD   = CW'(T_CMD_CYC - 1);
  localparam logic [CW-1:0] C_CLR   = CW'(T_CLR_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT, PWRUP} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            pend_q;
  logic [9:0]      pend_word_q;
  logic            on_q;
  logic            rs_q;
  logic            en_q;
  logic            ovf_q;
  logic [7:0]      data_q;
  logic [9:0]      wr_word;
  logic            unused_word_bits;
  logic            expire;
  logic            seq_exp;
  logic            clr;
  logic            init_go;
  logic [9:0]      init_word;
  logic            launch_d;
  logic [9:0]      launch_word_d;
  logic            take_d;
  logic            capture_d;
  logic            ovf_set_d;

  assign wr_word          = {i_lcd_word[31], i_lcd_word[10], i_lcd_word[7:0]};
  assign unused_word_bits = ^{i_lcd_word[30:11], i_lcd_word[9:8]};
  assign expire           = cnt_q == '0;
  assign seq_exp          = expire && (state_q == WAIT || state_q == PWRUP);
  assign clr              = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

`ifdef LCD_CTRL_INIT_EN
  logic [2:0] init_idx_q;
  logic [7:0] init_cmd;
  assign init_go   = init_idx_q < 3'd6;
  assign init_cmd  = (init_idx_q < 3'd3) ? 8'h38 : (init_idx_q == 3'd3) ? 8'h0C :
                     (init_idx_q == 3'd4) ? 8'h01 : 8'h06;
  assign init_word = {1'b1, 1'b0, init_cmd};
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) init_idx_q <= '0;
    else if (seq_exp && init_go) init_idx_q <= init_idx_q + 3'd1;
`else
  assign init_go   = 1'b0;
  assign init_word = '0;
`endif

  // Slot handling: at WAIT expiry the slot drains first so a same-cycle write refills it.
  always_comb begin
    launch_d      = 1'b0;
    launch_word_d = wr_word;
    take_d        = 1'b0;
    capture_d     = 1'b0;
    ovf_set_d     = 1'b0;
    if (state_q == IDLE && !init_go) begin
      launch_d = i_lcd_wr;
    end else if (seq_exp && init_go) begin
      launch_d      = 1'b1;
      launch_word_d = init_word;
      capture_d     = i_lcd_wr && !pend_q;
      ovf_set_d     = i_lcd_wr && pend_q;
    end else if (seq_exp && pend_q) begin
      launch_d      = 1'b1;
      launch_word_d = pend_word_q;
      take_d        = 1'b1;
      capture_d     = i_lcd_wr;
    end else if (seq_exp) begin
      launch_d = i_lcd_wr;
    end else begin
      capture_d = i_lcd_wr && !pend_q;
      ovf_set_d = i_lcd_wr && pend_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      on_q        <= 1'b0;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      ovf_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      ovf_q  <= ovf_q | ovf_set_d;
      pend_q <= (pend_q && !take_d) || capture_d;
      if (capture_d) pend_word_q <= wr_word;
      if (launch_d) begin
        state_q                <= SETUP;
        cnt_q                  <= C_SETUP;
        {on_q, rs_q, data_q}   <= launch_word_d;
        en_q                   <= 1'b0;
      end else if (!expire) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        case (state_q)
          IDLE: if (init_go) begin
            state_q <= PWRUP;
            cnt_q   <= C_PWR;
            on_q    <= 1'b1;
          end
          SETUP: begin
            state_q <= PULSE;
            cnt_q   <= C_PULSE;
            en_q    <= 1'b1;
          end
          PULSE: begin
            state_q <= HOLD;
            cnt_q   <= C_HOLD;
            en_q    <= 1'b0;
          end
          HOLD: begin
            state_q <= WAIT;
            cnt_q   <= clr ? C_CLR : C_CMD;
          end
          WAIT: state_q <= IDLE;
          default: ;
        endcase
      end
    end
  end

  assign o_busy     = state_q != IDLE || pend_q;
  assign o_ovf      = ovf_q;
  assign o_status   = {30'b0, ovf_q, o_busy};
  assign o_lcd_on   = on_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_data = data_q;
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: table-driven single transfers plus hand-written queueing and reset sequences.
module tb_lcd_ctrl;
  localparam int T_SETUP = 2;
  localparam int T_PULSE = 23;
  localparam int T_HOLD  = 2;
  localparam int T_CMD   = 200;
  localparam int T_CLR   = 900;
  localparam int LEN_CMD = T_SETUP + T_PULSE + T_HOLD + T_CMD;
  localparam int LEN_CLR = T_SETUP + T_PULSE + T_HOLD + T_CLR;
  localparam int LIMIT   = 4 * LEN_CLR;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [31:0] i_lcd_word = '0;
  logic        i_lcd_wr = 1'b0;
  logic        o_busy, o_ovf, o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en;
  logic [31:0] o_status;
  logic [7:0]  o_lcd_data;

  lcd_ctrl #(
    .T_SETUP_CYC(T_SETUP), .T_PULSE_CYC(T_PULSE), .T_HOLD_CYC(T_HOLD),
    .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR), .CNT_W(17)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_lcd_word(i_lcd_word), .i_lcd_wr(i_lcd_wr),
    .o_busy(o_busy), .o_ovf(o_ovf), .o_status(o_status), .o_lcd_on(o_lcd_on),
    .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en), .o_lcd_data(o_lcd_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] w;
    logic        on;
    logic        rs;
    logic [7:0]  d;
    int          len;
  } vec_t;

  vec_t        tbl[7];
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt, np, stat_bad;
  int          rise_k[4], width[4];
  logic [7:0]  pdata[4];
  logic [31:0] pstat[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [31:0] w);
    i_lcd_word = w;
    i_lcd_wr = 1'b1;
    @(negedge i_clk);
    i_lcd_wr = 1'b0;
  endtask

  // Called at the negedge of cycle N+1; k counts cycles since the launching write.
  task automatic watch(input int k0, input logic [31:0] w0, input int k1, input logic [31:0] w1);
    logic prev_en;
    busy_cnt = 0;
    np = 0;
    stat_bad = 0;
    prev_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rise_k[i] = 0;
      width[i] = 0;
      pdata[i] = '0;
      pstat[i] = '0;
    end
    for (int k = 1; k <= LIMIT && o_busy; k++) begin
      busy_cnt++;
      if (o_status[0] !== 1'b1) stat_bad++;
      if (o_lcd_en && !prev_en) begin
        if (np < 4) begin
          rise_k[np] = k;
          pdata[np] = o_lcd_data;
          pstat[np] = o_status;
        end
        np++;
      end
      if (o_lcd_en && np > 0 && np <= 4) width[np-1]++;
      prev_en = o_lcd_en;
      i_lcd_wr = (k == k0) || (k == k1);
      i_lcd_word = (k == k1) ? w1 : w0;
      @(negedge i_clk);
    end
    i_lcd_wr = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'h8000_0441, 1'b1, 1'b1, 8'h41, LEN_CMD};
    tbl[1] = '{32'h8000_0001, 1'b1, 1'b0, 8'h01, LEN_CLR};
    tbl[2] = '{32'h0000_0002, 1'b0, 1'b0, 8'h02, LEN_CLR};
    tbl[3] = '{32'h7FFF_FB03, 1'b0, 1'b0, 8'h03, LEN_CLR};
    tbl[4] = '{32'h8000_0401, 1'b1, 1'b1, 8'h01, LEN_CMD};
    tbl[5] = '{32'h8000_0004, 1'b1, 1'b0, 8'h04, LEN_CMD};
    tbl[6] = '{32'h0000_0000, 1'b0, 1'b0, 8'h00, LEN_CMD};

    @(negedge i_clk);
    chk("rst_status", o_status, 32'h0);
    chk("rst_outs", {o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data}, 12'h0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    chk("idle_busy", o_busy, 1'b0);

    for (int i = 0; i < 7; i++) begin
      launch(tbl[i].w);
      chk($sformatf("v%0d_rs", i), o_lcd_rs, tbl[i].rs);
      chk($sformatf("v%0d_data", i), o_lcd_data, tbl[i].d);
      chk($sformatf("v%0d_on", i), o_lcd_on, tbl[i].on);
      chk($sformatf("v%0d_busy_en", i), {o_busy, o_lcd_en, o_lcd_rw}, 3'b100);
      watch(0, '0, 0, '0);
      chk($sformatf("v%0d_pulses", i), np, 1);
      chk($sformatf("v%0d_en_rise", i), rise_k[0], 3);
      chk($sformatf("v%0d_en_width", i), width[0], T_PULSE);
      chk($sformatf("v%0d_busy_len", i), busy_cnt, tbl[i].len);
      chk($sformatf("v%0d_status_busy", i), stat_bad, 0);
      chk($sformatf("v%0d_status_idle", i), o_status, 32'h0);
      chk($sformatf("v%0d_hold", i), {o_lcd_on, o_lcd_rs, o_lcd_data}, {tbl[i].on, tbl[i].rs, tbl[i].d});
    end

    launch(32'h8000_0441);
    watch(1, 32'h8000_0442, 2, 32'h8000_0443);
    chk("b2b_pulses", np, 2);
    chk("b2b_data0", pdata[0], 8'h41);
    chk("b2b_data1", pdata[1], 8'h42);
    chk("b2b_rise1", rise_k[1], LEN_CMD + 3);
    chk("b2b_status2", pstat[1], 32'h3);
    chk("b2b_busy_len", busy_cnt, 2 * LEN_CMD);
    chk("b2b_status_idle", o_status, 32'h2);

    launch(32'h8000_0441);
    for (int k = 0; k < 10 && !o_lcd_en; k++) @(negedge i_clk);
    chk("rst_pre_en", o_lcd_en, 1'b1);
    @(negedge i_clk);
    #2 i_rstn = 1'b0;
    #1;
    chk("arst_en", o_lcd_en, 1'b0);
    chk("arst_status", o_status, 32'h0);
    chk("arst_outs", {o_lcd_on, o_lcd_rs, o_lcd_data}, 10'h0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    launch(32'h8000_0442);
    watch(0, '0, 0, '0);
    chk("post_rst_pulses", np, 1);
    chk("post_rst_data", pdata[0], 8'h42);
    chk("post_rst_len", busy_cnt, LEN_CMD);

    launch(32'h8000_0441);
    watch(LEN_CMD, 32'h8000_0442, 0, '0);
    chk("last_wait_pulses", np, 2);
    chk("last_wait_data1", pdata[1], 8'h42);
    chk("last_wait_rise1", rise_k[1], LEN_CMD + 3);
    chk("last_wait_len", busy_cnt, 2 * LEN_CMD);
    chk("last_wait_ovf", o_ovf, 1'b0);

    launch(32'h8000_0441);
    watch(1, 32'h8000_0442, LEN_CMD, 32'h8000_0443);
    chk("simul_pulses", np, 3);
    chk("simul_data2", pdata[2], 8'h43);
    chk("simul_len", busy_cnt, 3 * LEN_CMD);
    chk("simul_ovf", o_ovf, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Timing engine downstream of the LSU's LCD output register.
- Converts each software write to the LCD address (32-bit word plus one-cycle write strobe) into a correctly timed HD44780 8-bit bus transaction: setup, enable pulse, hold, execution wait.
- Buffers one pending write while busy and reports busy/overflow status for software polling through the LSU read mux.

Parameters:
- T_SETUP_CYC, 2: cycles RS/DATA are stable before EN rises.
- T_PULSE_CYC, 23: cycles EN is high (≥450 ns at 50 MHz).
- T_HOLD_CYC, 2: cycles RS/DATA are held after EN falls.
- T_CMD_CYC, 2000: execution wait for normal commands and data (40 µs).
- T_CLR_CYC, 82000: execution wait for clear-display and return-home (1.64 ms).
- CNT_W, 17: timing counter width; must satisfy 2^CNT_W > every T_* value.

Ports:
- i_clk, input, 1: system clock.
- i_rstn, input, 1: reset. One clock; reset is asynchronous and active-low.
- i_lcd_word, input, 32: write word. Bit31 = LCD_ON, bit10 = RS, bits7:0 = DATA. All other bits ignored.
- i_lcd_wr, input, 1: one-cycle write strobe, asserted when a store hits the LCD address.
- o_busy, output, 1: high while a transaction is in progress or a write is pending.
- o_ovf, output, 1: sticky; a write was dropped.
- o_status, output, 32: {30'b0, o_ovf, o_busy}, read back by the LSU.
- o_lcd_on, output, 1: panel power/backlight enable.
- o_lcd_rs, output, 1: HD44780 RS.
- o_lcd_rw, output, 1: HD44780 RW; tied to 0 (write only).
- o_lcd_en, output, 1: HD44780 E.
- o_lcd_data, output, 8: HD44780 DB7..DB0.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - state = IDLE; pending slot empty; counter = 0.
  - All outputs 0. o_lcd_en drops to 0 the same instant.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. Registered outputs only.
- IDLE:
  - i_lcd_wr=1 in cycle N launches the word. In cycle N+1: state = SETUP, o_busy = 1, o_lcd_rs/o_lcd_data/o_lcd_on take the word's fields.
- SETUP: lasts T_SETUP_CYC cycles, EN = 0, then go to PULSE.
- PULSE: lasts T_PULSE_CYC cycles, EN = 1, then go to HOLD.
- HOLD: lasts T_HOLD_CYC cycles, EN = 0, RS/DATA unchanged, then go to WAIT.
- WAIT:
  - Duration is T_CLR_CYC if RS=0 and DATA ∈ {0x01, 0x02, 0x03}; otherwise T_CMD_CYC.
  - On expiry with pending full: go directly to SETUP with the pending word (no IDLE cycle) and empty the slot.
  - On expiry with pending empty: go to IDLE; o_busy = 0 the next cycle.
- Single-write busy duration: T_SETUP+T_PULSE+T_HOLD+wait cycles. At defaults: 2027 (normal) or 84027 (clear).
- Write while state ≠ IDLE:
  - Pending slot empty: capture the full word.
  - Pending slot full: drop the write and set o_ovf.
  - A write in the final WAIT cycle counts as "state ≠ IDLE".
- o_ovf is cleared only by reset.
- Simultaneous WAIT expiry and i_lcd_wr with pending full: the pending word launches, the new word fills the now-empty slot, no overflow.
- o_busy = (state ≠ IDLE) | pending_full.
- o_lcd_rs/o_lcd_data hold their last values in IDLE.
- o_lcd_on changes only when a word is launched, not when it is captured into pending.
- The counter loads (T_x − 1) on state entry and advances on reaching 0. Any T_x = 0 is illegal.

Optional Feature:
- Macro: LCD_CTRL_INIT_EN.
- Defined:
  - After reset, run the HD44780 init sequence before accepting writes: wait 750000 cycles (15 ms), then issue commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - Each command uses the normal SETUP/PULSE/HOLD/WAIT path; 0x01 uses T_CLR_CYC.
  - o_lcd_on = 1 throughout init; o_busy = 1 throughout init.
  - Writes during init are captured into pending per the normal rules.
- Undefined: the block is ready in IDLE immediately after reset.

Test Plan:
- Single data write, i_lcd_word=0x8000_0441 (LCD_ON=1, RS=1, DATA=0x41) -> rs=1, data=0x41, on=1 from N+1; EN high for exactly 23 cycles, starting at N+3; o_busy falls after 2027 cycles.
- Clear command, word=0x8000_0001 -> EN pulse as above; o_busy high for 84027 cycles; o_status=0x1 while busy, then 0x0.
- Back-to-back: three writes 0x41, 0x42, 0x43 in consecutive cycles -> 0x41 and 0x42 each transferred with their own EN pulse; 0x43 dropped; o_ovf=1 and o_status=0x3 during the second transfer; o_ovf stays 1 after idle.
- Write on the final WAIT cycle of a 0x41 transfer -> captured, not dropped; next SETUP starts the cycle immediately after WAIT ends; o_ovf=0.
- Assert i_rstn=0 during PULSE -> o_lcd_en=0 asynchronously; all outputs 0; after release, a new write completes normally.
- With LCD_CTRL_INIT_EN defined: reset release -> six EN pulses with DATA 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in that order, the first after ≥750000 cycles; o_busy deasserts only after the 0x06 wait.
